// File: rtl/pc_sequencer.sv
// Next-PC controller: owns the program counter, runs the I-mem req/ack fetch handshake,
// and arbitrates exception, jump and branch redirects over sequential advance and stall.
module pc_sequencer #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter logic [31:0] EXC_VECTOR   = 32'h8000_0180
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_stall,
    input  logic        i_br_taken,
    input  logic [31:0] i_br_target,
    input  logic        i_jump,
    input  logic [31:0] i_jump_target,
    input  logic        i_exc,
    input  logic        i_fetch_ack,
    output logic        o_fetch_req,
    output logic [31:0] o_fetch_addr,
    output logic [31:0] o_pc,
    output logic [31:0] o_pc_plus4,
    output logic        o_flush,
    output logic [31:0] o_epc,
    output logic        o_addr_err
);

    typedef enum logic [1:0] {
        StBoot  = 2'd0,
        StFetch = 2'd1,
        StHold  = 2'd2
    } state_e;

    state_e      r_state;
    logic [31:0] r_pc;
    logic [31:0] r_epc;
    logic        r_fetch_req;
    logic        r_flush;
    logic        r_addr_err;

    logic [31:0] w_pc_plus4;
    logic        w_redirect;
    logic [31:0] w_redir_raw;

    assign w_pc_plus4  = r_pc + 32'd4;
    assign w_redirect  = i_jump | i_br_taken;
    assign w_redir_raw = i_jump ? i_jump_target : i_br_target;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= StBoot;
            r_pc        <= RESET_VECTOR;
            r_epc       <= 32'h0000_0000;
            r_fetch_req <= 1'b0;
            r_flush     <= 1'b0;
            r_addr_err  <= 1'b0;
        end else begin
            r_flush    <= 1'b0;
            r_addr_err <= 1'b0;
            unique case (r_state)
                StBoot: begin
                    r_state     <= StFetch;
                    r_fetch_req <= 1'b1;
                end
                StFetch, StHold: begin
                    if (i_exc) begin
                        r_epc       <= r_pc;
                        r_pc        <= EXC_VECTOR;
                        r_flush     <= 1'b1;
                        r_state     <= StFetch;
                        r_fetch_req <= 1'b1;
                    end else if (w_redirect) begin
                        // Misaligned targets are truncated to the word and flagged.
                        r_pc        <= {w_redir_raw[31:2], 2'b00};
                        r_addr_err  <= |w_redir_raw[1:0];
                        r_flush     <= 1'b1;
                        r_state     <= StFetch;
                        r_fetch_req <= 1'b1;
                    end else if (r_state == StFetch) begin
                        if (i_fetch_ack && !i_stall) begin
                            r_pc <= w_pc_plus4;
                        end else if (i_fetch_ack && i_stall) begin
                            r_state     <= StHold;
                            r_fetch_req <= 1'b0;
                        end
                    end else begin
                        if (!i_stall) begin
                            r_pc        <= w_pc_plus4;
                            r_state     <= StFetch;
                            r_fetch_req <= 1'b1;
                        end
                    end
                end
                default: begin
                    r_state     <= StBoot;
                    r_fetch_req <= 1'b0;
                end
            endcase
        end
    end

    assign o_fetch_req  = r_fetch_req;
    assign o_fetch_addr = r_pc;
    assign o_pc         = r_pc;
    assign o_pc_plus4   = w_pc_plus4;
    assign o_flush      = r_flush;
    assign o_epc        = r_epc;
    assign o_addr_err   = r_addr_err;

endmodule
